// File: rtl/sha256_pkg.sv
// sha256_pkg: shared definitions for the SHA-256 message-schedule slice.
//   WORD_W     - schedule word width (32)
//   SCHED_LEN  - number of schedule words per block (64)
//   WINDOW_LEN - depth of the sliding window of past words (16)
//   state_t    - message-schedule controller states
//   sigma0/1   - SHA-256 small sigma functions used in the expansion
package sha256_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned SCHED_LEN  = 64;
  localparam int unsigned WINDOW_LEN = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXPAND,
    DONE
  } state_t;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned       n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/msg_window.sv
// msg_window: 16 x 32-bit shift register holding the most recent schedule
// words. Entry 0 is the newest word; tapN is the word N positions back.
//   clock    - rising-edge clock
//   reset    - asynchronous active-low clear of all entries
//   shift_en - shift shift_in into the window, dropping the oldest word
//   shift_in - word to insert
//   tap2/7/15/16 - window words at depths 2, 7, 15 and 16
module msg_window
  import sha256_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              shift_en,
  input  logic [WORD_W-1:0] shift_in,
  output logic [WORD_W-1:0] tap2,
  output logic [WORD_W-1:0] tap7,
  output logic [WORD_W-1:0] tap15,
  output logic [WORD_W-1:0] tap16
);

  logic [WORD_W-1:0] win [WINDOW_LEN];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < WINDOW_LEN; i++) win[i] <= '0;
    end else if (shift_en) begin
      win[0] <= shift_in;
      for (int unsigned i = 1; i < WINDOW_LEN; i++) win[i] <= win[i-1];
    end
  end

  assign tap2  = win[1];
  assign tap7  = win[6];
  assign tap15 = win[14];
  assign tap16 = win[15];

endmodule

// File: rtl/msg_schedule.sv
// msg_schedule: on a rising edge of enable, reads one 512-bit block as 16
// words from message memory, then streams SHA-256 schedule W[0..63], one
// word per cycle, with a one-cycle done pulse after the last word.
//   clock    - rising-edge clock
//   reset    - asynchronous active-low reset
//   enable   - start level; a 0->1 transition seen in IDLE starts a run
//   mem_data - memory read data, valid the cycle after mem_rd
//   mem_rd   - memory read strobe
//   mem_addr - memory word address (BASE_ADDR + k, wrapping)
//   w_valid  - w_out / w_index valid
//   w_out    - schedule word W[t]
//   w_index  - t
//   busy     - run in progress
//   done     - one-cycle pulse after W[63]
module msg_schedule
  import sha256_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       NUM_WORDS = SCHED_LEN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [31:0]       mem_data,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              w_valid,
  output logic [31:0]       w_out,
  output logic [5:0]        w_index,
  output logic              busy,
  output logic              done
);

  localparam logic [5:0] LAST_T = 6'(NUM_WORDS - 1);

  state_t      state;
  logic        en_q;
  logic        rd_q;
  logic [4:0]  rd_cnt;
  logic [5:0]  t;
  logic        start;
  logic        shift_en;
  logic [31:0] shift_in;
  logic [31:0] w_new;
  logic [31:0] tap2, tap7, tap15, tap16;

  msg_window u_window (
    .clock    (clock),
    .reset    (reset),
    .shift_en (shift_en),
    .shift_in (shift_in),
    .tap2     (tap2),
    .tap7     (tap7),
    .tap15    (tap15),
    .tap16    (tap16)
  );

  // Blocking start while done is high keeps the earliest restart one cycle
  // after the done pulse.
  assign start = (state == IDLE) && !done && enable && !en_q;

  always_comb begin
    w_new    = sigma1(tap2) + tap7 + sigma0(tap15) + tap16;
    shift_en = ((state == FETCH) && rd_q) || (state == EXPAND);
    shift_in = (state == EXPAND) ? w_new : mem_data;
  end

  // rd_q marks the cycle in which mem_data carries a requested word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      en_q     <= 1'b0;
      rd_q     <= 1'b0;
      rd_cnt   <= '0;
      t        <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      w_valid  <= 1'b0;
      w_out    <= '0;
      w_index  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      en_q <= enable;
      rd_q <= mem_rd;
      done <= 1'b0;
      case (state)
        IDLE: begin
          w_valid <= 1'b0;
          if (start) begin
            state    <= FETCH;
            busy     <= 1'b1;
            mem_rd   <= 1'b1;
            mem_addr <= BASE_ADDR;
            rd_cnt   <= 5'd1;
            t        <= '0;
          end
        end
        FETCH: begin
          if (rd_cnt < 5'd16) begin
            mem_addr <= mem_addr + 1'b1;
            rd_cnt   <= rd_cnt + 5'd1;
          end else begin
            mem_rd <= 1'b0;
          end
          w_valid <= rd_q;
          if (rd_q) begin
            w_out   <= mem_data;
            w_index <= t;
            t       <= t + 6'd1;
            if (t == 6'd15) state <= EXPAND;
          end
        end
        EXPAND: begin
          w_valid <= 1'b1;
          w_out   <= w_new;
          w_index <= t;
          t       <= t + 6'd1;
          if (t == LAST_T) state <= DONE;
        end
        DONE: begin
          w_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
